im_loader: RTL and testbench

Program loader: the write-side counterpart of the instruction memory. It accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and issues one write per word into the instruction memory at consecutive word addresses starting from the text base 0x0000_3000. It is used at bring-up to fill instruction memory before the CPU leaves reset, replacing the static hex-file preload.

---
 rtl/mips_defs_pkg.sv | 20 ++
 rtl/im_loader_byte_packer.sv | 36 +++
 rtl/im_loader.sv | 127 ++++++++++++
 tb/tb_im_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS bring-up definitions: text base, memory depth and loader state encoding.
package mips_defs;

  localparam logic [31:0] PC_BASE  = 32'h0000_3000;
  localparam int unsigned IM_DEPTH = 1024;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WC_W   = 10;  // word_count request width
  localparam int unsigned WW_W   = 11;  // words_written width, holds 0..IM_DEPTH

  // Exported so debug/trace logic can decode the loader state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/im_loader_byte_packer.sv
// Big-endian byte packer: holds the three leading bytes of a word and merges the
// fourth on the fly, so the completed word is available in the cycle it arrives.
module byte_packer
  import mips_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [WORD_W-BYTE_W-1:0] hold_q;
  logic [1:0]               cnt_q;

  // Shift accepted bytes in; the 2-bit count wraps back to 0 on the fourth byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else if (push) begin
      hold_q <= {hold_q[WORD_W-2*BYTE_W-1:0], byte_in};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  // Three bytes held: the next push completes the word.
  assign full = (cnt_q == 2'd3);
  assign word = {hold_q, byte_in};

endmodule

// File: rtl/im_loader.sv
// Program loader: packs a byte stream into 32-bit words and writes them to
// instruction memory at consecutive word addresses from PC_BASE.
module im_loader
  import mips_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WC_W-1:0]   word_count,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [WORD_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              busy,
  output logic              done,
  output logic [WW_W-1:0]   words_written
);

  loader_state_t     state_q, state_d;
  logic [WW_W-1:0]   count_q;
  logic              load_start;
  logic              push;
  logic              word_done;
  logic              last_word;
  logic [WORD_W-1:0] pk_word;
  logic              pk_full;

  byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .clear   (load_start | abort),
    .byte_in (in_data),
    .word    (pk_word),
    .full    (pk_full)
  );

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    word_done  = 1'b0;
    push       = in_ready & in_valid & ~abort;
    last_word  = (WW_W'(words_written + WW_W'(1)) == count_q);
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (push && pk_full) begin
          state_d   = WRITE;
          word_done = 1'b1;
        end
      end
      WRITE: begin
        if (abort)          state_d = IDLE;
        else if (last_word) state_d = DONE;
        else                state_d = LOAD;
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d    = LOAD;
          load_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_d == LOAD);
      im_we    <= (state_d == WRITE);
      busy     <= (state_d == LOAD) || (state_d == WRITE);
      done     <= (state_d == DONE);
    end
  end

  // Word count latch, address counter, write data and written-word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      im_addr       <= PC_BASE;
      im_wdata      <= '0;
      words_written <= '0;
    end else begin
      if (load_start) begin
        count_q       <= (word_count == '0) ? WW_W'(IM_DEPTH) : WW_W'(word_count);
        im_addr       <= PC_BASE;
        words_written <= '0;
      end
      if (word_done) begin
        im_wdata <= pk_word;
      end
      // The write completes on this edge even when abort is high.
      if (state_q == WRITE) begin
        words_written <= words_written + WW_W'(1);
        if (!abort && !last_word) begin
          im_addr <= im_addr + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: randomized byte streams against a
// word-list reference model of the expected instruction memory writes.
module tb_im_loader;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, start, abort, in_valid;
  logic [9:0]  word_count;
  logic [7:0]  in_data;
  logic        in_ready, im_we, busy, done;
  logic [31:0] im_addr, im_wdata;
  logic [10:0] words_written;

  im_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .word_count    (word_count),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .im_we         (im_we),
    .im_addr       (im_addr),
    .im_wdata      (im_wdata),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  logic [7:0]  stim [4096];
  logic [31:0] obs_addr [$];
  logic [31:0] obs_data [$];
  int          obs_cyc  [$];
  int          cyc = 0;
  int          done_rise_cyc = -1;
  logic        done_prev = 1'b0;
  bit          overlap = 1'b0;

  // Write monitor: records every memory write with its cycle number.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (im_we === 1'b1) begin
      obs_addr.push_back(im_addr);
      obs_data.push_back(im_wdata);
      obs_cyc.push_back(cyc);
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
    done_prev = done;
    if (done === 1'b1 && busy === 1'b1) overlap = 1'b1;
  end

  // Reference model: word i is bytes 4i..4i+3, first byte most significant.
  function automatic logic [31:0] exp_word(int i);
    return {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
  endfunction

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  task automatic pulse_start(input logic [9:0] wc);
    @(negedge clk);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start      = 1'b0;
    word_count = 10'($urandom);
  endtask

  // mode 0: full rate, 1: valid every other cycle, 2: random stalls.
  task automatic feed(input int nbytes, input int mode, input bit spam, output bit ok);
    int idx = 0;
    int guard = 0;
    bit tog = 1'b1;
    bit v;
    while (idx < nbytes && guard < 20 * nbytes + 50) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 99) < 60);
      endcase
      in_valid = v;
      in_data  = stim[idx];
      start    = (spam && busy && $urandom_range(0, 5) == 0);
      if (spam && start) word_count = 10'($urandom);
      if (v && in_ready) idx++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    ok = (idx == nbytes);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = '0; word_count = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if ({in_ready, im_we, busy, done} !== 4'b0000) begin
      nfail++; $display("FAIL reset_flags got %b want 0000", {in_ready, im_we, busy, done});
    end
    nvec++;
    if (im_addr !== BASE) begin
      nfail++; $display("FAIL reset_addr got %h want %h", im_addr, BASE);
    end
    nvec++;
    if (im_wdata !== 32'h0) begin
      nfail++; $display("FAIL reset_wdata got %h want 0", im_wdata);
    end
    nvec++;
    if (words_written !== 11'd0) begin
      nfail++; $display("FAIL reset_count got %0d want 0", words_written);
    end
  endtask

  task automatic test_two_words();
    logic [7:0] pat [8] = '{8'h3C, 8'h01, 8'h00, 8'h12, 8'h34, 8'h21, 8'h56, 8'h78};
    logic [31:0] want [2] = '{32'h3C01_0012, 32'h3421_5678};
    bit fed, fin;
    for (int i = 0; i < 8; i++) stim[i] = pat[i];
    clear_obs();
    pulse_start(10'd2);
    nvec++;
    if (in_ready !== 1'b1) begin
      nfail++; $display("FAIL two_start_latency in_ready=%b want 1", in_ready);
    end
    feed(8, 0, 1'b0, fed);
    wait_done(40, fin);
    repeat (2) @(negedge clk);
    nvec++;
    if (!(fed && fin)) begin
      nfail++; $display("FAIL two_timeout fed=%0b done=%0b want 1 1", fed, fin);
    end
    nvec++;
    if (obs_addr.size() != 2) begin
      nfail++; $display("FAIL two_nwrites got %0d want 2", obs_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        nvec++;
        if (obs_addr[i] !== BASE + 32'(4 * i) || obs_data[i] !== want[i]) begin
          nfail++;
          $display("FAIL two_write%0d got %h:%h want %h:%h", i, obs_addr[i], obs_data[i],
                   BASE + 32'(4 * i), want[i]);
        end
      end
      nvec++;
      if (obs_cyc[1] - obs_cyc[0] != 5) begin
        nfail++; $display("FAIL two_spacing got %0d cycles want 5", obs_cyc[1] - obs_cyc[0]);
      end
      nvec++;
      if (done_rise_cyc != obs_cyc[1] + 1) begin
        nfail++; $display("FAIL two_done_latency got %0d want %0d", done_rise_cyc, obs_cyc[1] + 1);
      end
    end
    nvec++;
    if (words_written !== 11'd2) begin
      nfail++; $display("FAIL two_count got %0d want 2", words_written);
    end
    // Bytes offered in DONE must be refused.
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(negedge clk);
    nvec++;
    if (in_ready !== 1'b0 || done !== 1'b1 || im_addr !== BASE + 32'd4) begin
      nfail++; $display("FAIL two_done_hold rdy=%b done=%b addr=%h want 0 1 %h",
                        in_ready, done, im_addr, BASE + 32'd4);
    end
    in_valid = 1'b0;
    @(negedge clk);
    nvec++;
    if (obs_addr.size() != 2) begin
      nfail++; $display("FAIL two_done_nowrite got %0d writes want 2", obs_addr.size());
    end
  endtask

  task automatic test_stream(input string name, input int nw, input int mode,
                             input bit spam, input bit fresh);
    bit fed, fin;
    if (fresh) for (int i = 0; i < 4 * nw; i++) stim[i] = 8'($urandom);
    clear_obs();
    pulse_start(10'(nw));
    nvec++;
    if (in_ready !== 1'b1) begin
      nfail++; $display("FAIL %s start_latency in_ready=%b want 1", name, in_ready);
    end
    feed(4 * nw, mode, spam, fed);
    wait_done(40, fin);
    repeat (2) @(negedge clk);
    nvec++;
    if (!(fed && fin)) begin
      nfail++; $display("FAIL %s timeout fed=%0b done=%0b want 1 1", name, fed, fin);
    end
    nvec++;
    if (obs_addr.size() != nw) begin
      nfail++; $display("FAIL %s nwrites got %0d want %0d", name, obs_addr.size(), nw);
    end
    for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
      nvec++;
      if (obs_addr[i] !== BASE + 32'(4 * i) || obs_data[i] !== exp_word(i)) begin
        nfail++;
        $display("FAIL %s write%0d got %h:%h want %h:%h", name, i, obs_addr[i], obs_data[i],
                 BASE + 32'(4 * i), exp_word(i));
      end
    end
    nvec++;
    if (words_written !== 11'(nw)) begin
      nfail++; $display("FAIL %s count got %0d want %0d", name, words_written, nw);
    end
    nvec++;
    if ({done, busy, in_ready} !== 3'b100) begin
      nfail++; $display("FAIL %s end_flags done/busy/rdy got %b want 100", name, {done, busy, in_ready});
    end
  endtask

  task automatic test_full_depth();
    test_stream("depth", 1024, 0, 1'b0, 1'b1);
    nvec++;
    if (obs_addr.size() == 0 || obs_addr[obs_addr.size() - 1] !== 32'h0000_3FFC) begin
      nfail++; $display("FAIL depth_last_addr got %h want 00003ffc",
                        (obs_addr.size() == 0) ? 32'h0 : obs_addr[obs_addr.size() - 1]);
    end
  endtask

  task automatic test_abort();
    bit fed;
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
    clear_obs();
    pulse_start(10'd2);
    feed(6, 0, 1'b0, fed);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if (!fed || obs_addr.size() != 1) begin
      nfail++; $display("FAIL abort_nwrites got %0d fed=%0b want 1 1", obs_addr.size(), fed);
    end else begin
      nvec++;
      if (obs_addr[0] !== BASE || obs_data[0] !== exp_word(0)) begin
        nfail++; $display("FAIL abort_write got %h:%h want %h:%h", obs_addr[0], obs_data[0],
                          BASE, exp_word(0));
      end
    end
    nvec++;
    if ({in_ready, busy, done, im_we} !== 4'b0000) begin
      nfail++; $display("FAIL abort_idle rdy/busy/done/we got %b want 0000",
                        {in_ready, busy, done, im_we});
    end
    nvec++;
    if (words_written !== 11'd1) begin
      nfail++; $display("FAIL abort_count got %0d want 1", words_written);
    end
    test_stream("after_abort", 2, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_in_write();
    bit fed;
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
    clear_obs();
    pulse_start(10'd2);
    feed(4, 0, 1'b0, fed);
    nvec++;
    if (!fed || im_we !== 1'b1 || im_wdata !== exp_word(0)) begin
      nfail++; $display("FAIL rstw_in_write we=%b data=%h want 1 %h", im_we, im_wdata, exp_word(0));
    end
    #1 reset = 1'b1;
    #1;
    nvec++;
    if ({in_ready, im_we, busy, done} !== 4'b0000 || im_addr !== BASE ||
        im_wdata !== 32'h0 || words_written !== 11'd0) begin
      nfail++;
      $display("FAIL rstw_async flags=%b addr=%h data=%h cnt=%0d want 0000 %h 0 0",
               {in_ready, im_we, busy, done}, im_addr, im_wdata, words_written, BASE);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_stream("toggle", 2, 1, 1'b0, 1'b0);
    test_full_depth();
    test_abort();
    test_reset_in_write();
    test_stream("start_busy", 5, 2, 1'b1, 1'b1);
    for (int r = 0; r < 6; r++) begin
      test_stream("random", int'($urandom_range(1, 8)), 2, 1'b0, 1'b1);
    end
    nvec++;
    if (overlap) begin
      nfail++; $display("FAIL done_busy_overlap got 1 want 0");
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
